// File: rtl/lsu_align.sv
// lsu_align: maps byte-addressed loads/stores onto a word-organised data memory.
// Build with LSU_MISALIGN_EN to split misaligned H/W accesses over two words; otherwise they are rejected.
module lsu_align #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              misalign_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_load_type,
  input  logic [31:0]       mem_rdata
);

  function automatic logic [31:0] extend_load(input logic [31:0] v, input logic b,
                                              input logic h, input logic sgn);
    if (b) return sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
    if (h) return sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
    return v;
  endfunction

  logic [1:0]        off;
  logic [ADDR_W-1:0] word_n;
  logic              is_b, is_h, is_sgn, misaligned;
  logic [4:0]        lo_sh;
  logic [31:0]       size_mask, lo_mask, store_lo, load_aligned;

  assign off        = addr[1:0];
  assign word_n     = addr[ADDR_W+1:2];
  assign is_b       = (funct3[1:0] == 2'b00);
  assign is_h       = (funct3[1:0] == 2'b01);
  assign is_sgn     = ~funct3[2];
  assign misaligned = is_h ? (off == 2'd3) : (!is_b && (off != 2'd0));
  assign size_mask  = is_b ? 32'h0000_00FF : (is_h ? 32'h0000_FFFF : '1);
  assign lo_sh      = {off, 3'b000};

  // Shifting left truncates the lane mask at byte 3, so the same merge serves
  // both an aligned store and the first half of a split store.
  assign lo_mask      = size_mask << lo_sh;
  assign store_lo     = (mem_rdata & ~lo_mask) | ((wdata << lo_sh) & lo_mask);
  assign load_aligned = extend_load(mem_rdata >> lo_sh, is_b, is_h, is_sgn);

  assign mem_load_type = 3'b010;

`ifdef LSU_MISALIGN_EN
  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state;
  logic [31:0] lo_reg, hi_mask, store_hi, load_split;
  logic [1:0]  lo_cnt;
  logic [4:0]  hi_sh;
  logic        unused_bits;

  // lo_cnt = bytes taken from word N (4 - off, never 4 when split).
  assign lo_cnt     = 2'd0 - off;
  assign hi_sh      = {lo_cnt, 3'b000};
  assign hi_mask    = size_mask >> hi_sh;
  assign store_hi   = (mem_rdata & ~hi_mask) | ((wdata >> hi_sh) & hi_mask);
  assign load_split = extend_load(lo_reg | (mem_rdata << hi_sh), is_b, is_h, is_sgn);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      lo_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && misaligned) begin
            state <= SECOND;
            if (!req_we) lo_reg <= mem_rdata >> lo_sh;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign unused_bits = ^addr[31:ADDR_W+2];
`else
  logic unused_bits;
  assign unused_bits = ^{clk, addr[31:ADDR_W+2]};
`endif

  always_comb begin
    mem_addr     = word_n;
    mem_we       = 1'b0;
    mem_wdata    = store_lo;
    rdata        = '0;
    rdata_valid  = 1'b0;
    stall        = 1'b0;
    misalign_err = 1'b0;
`ifdef LSU_MISALIGN_EN
    if (state == SECOND) begin
      mem_addr = word_n + ADDR_W'(1);
      if (req_we) begin
        mem_we    = 1'b1;
        mem_wdata = store_hi;
      end else begin
        rdata       = load_split;
        rdata_valid = 1'b1;
      end
    end else
`endif
    if (req_valid) begin
      if (misaligned) begin
`ifdef LSU_MISALIGN_EN
        stall  = 1'b1;
        mem_we = req_we;
`else
        misalign_err = 1'b1;
`endif
      end else if (req_we) begin
        mem_we = 1'b1;
      end else begin
        rdata       = load_aligned;
        rdata_valid = 1'b1;
      end
    end
    if (reset) begin
      mem_we       = 1'b0;
      stall        = 1'b0;
      rdata_valid  = 1'b0;
      misalign_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align against a byte-array memory model.
// Expectations follow LSU_MISALIGN_EN the same way the design build does.
module tb_lsu_align;
  localparam int ADDR_W = 10;
  localparam int WORDS  = 1024;
`ifdef LSU_MISALIGN_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              req_valid, req_we;
  logic [2:0]        funct3;
  logic [31:0]       addr, wdata, rdata, mem_wdata, mem_rdata;
  logic              rdata_valid, stall, misalign_err, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_load_type;

  logic [31:0] mem [WORDS];
  logic [7:0]  ref_mem [WORDS*4];
  int checks = 0;
  int errors = 0;

  assign mem_rdata = mem[mem_addr];

  lsu_align #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .stall(stall), .misalign_err(misalign_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_load_type(mem_load_type), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_misal(input logic [31:0] a, input logic [2:0] f3);
    return (int'(a[1:0]) + int'(acc_size(f3))) > 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int unsigned b, n;
    logic [31:0] v;
    b = a[11:0];
    n = acc_size(f3);
    v = '0;
    for (int unsigned i = 0; i < n; i++)
      v = v | (32'(ref_mem[(b + i) % (WORDS*4)]) << (8*i));
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8*n-1])
      for (int unsigned i = n; i < 4; i++) v = v | (32'hFF << (8*i));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    int unsigned b;
    b = a[11:0];
    for (int unsigned i = 0; i < acc_size(f3); i++)
      ref_mem[(b + i) % (WORDS*4)] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int unsigned w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  function automatic int mem_mismatches();
    int bad;
    bad = 0;
    for (int unsigned w = 0; w < WORDS; w++) if (mem[w] !== ref_word(w)) bad++;
    return bad;
  endfunction

  task automatic set_word(input int unsigned w, input logic [31:0] v);
    mem[w] = v;
    for (int unsigned i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
  endtask

  // Holds one request until stall drops (bounded) and plays the memory's write port.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic f_stall, output logic f_err,
                            output logic f_we, output logic [31:0] l_rdata,
                            output logic l_valid, output int cycles);
    logic cur_stall, wr;
    logic [ADDR_W-1:0] wa;
    logic [31:0] wv;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    cycles = 0;
    f_stall = 1'b0; f_err = 1'b0; f_we = 1'b0;
    do begin
      #2;
      if (cycles == 0) begin f_stall = stall; f_err = misalign_err; f_we = mem_we; end
      cur_stall = stall; l_rdata = rdata; l_valid = rdata_valid;
      wr = mem_we; wa = mem_addr; wv = mem_wdata;
      @(posedge clk);
      #1;
      if (wr) mem[wa] = wv;
      cycles++;
      if (cur_stall) @(negedge clk);
    end while (cur_stall && cycles < 4);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010;
    addr = 32'h6; wdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we);
    if (mem_we !== 1'b0) errors++;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", misalign_err); end
    req_we = 1'b0;
    #1;
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rdata_valid); end
    checks++; if (mem_load_type !== 3'b010) begin errors++; $display("FAIL load_type got %b want 010", mem_load_type); end
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0; #2;
    checks++; if (stall !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got stall=%b we=%b want 0 0", stall, mem_we);
    end
  endtask

  task automatic test_directed();
    logic fs, fe, fw, lv;
    logic [31:0] lr;
    int cyc;
    set_word(0, 32'h8899_AABB);
    run_access(1'b0, 3'b000, 32'h1, 32'h0, fs, fe, fw, lr, lv, cyc);
    checks++; if (lr !== 32'hFFFF_FFAA || lv !== 1'b1 || fs !== 1'b0) begin
      errors++; $display("FAIL lb_1 got %h v=%b s=%b want ffffffaa 1 0", lr, lv, fs);
    end
    run_access(1'b0, 3'b100, 32'h2, 32'h0, fs, fe, fw, lr, lv, cyc);
    checks++; if (lr !== 32'h0000_0099) begin errors++; $display("FAIL lbu_2 got %h want 00000099", lr); end
    run_access(1'b0, 3'b001, 32'h2, 32'h0, fs, fe, fw, lr, lv, cyc);
    checks++; if (lr !== 32'hFFFF_8899) begin errors++; $display("FAIL lh_2 got %h want ffff8899", lr); end
    run_access(1'b1, 3'b000, 32'h3, 32'h1234_5611, fs, fe, fw, lr, lv, cyc);
    ref_store(32'h3, 3'b000, 32'h1234_5611);
    checks++; if (mem[0] !== 32'h1199_AABB) begin errors++; $display("FAIL sb_3 got %h want 1199aabb", mem[0]); end
    run_access(1'b1, 3'b001, 32'h0, 32'h0000_CAFE, fs, fe, fw, lr, lv, cyc);
    ref_store(32'h0, 3'b001, 32'h0000_CAFE);
    checks++; if (mem[0] !== 32'h1199_CAFE) begin errors++; $display("FAIL sh_0 got %h want 1199cafe", mem[0]); end

    set_word(1, 32'h4433_2211);
    set_word(2, 32'h8877_6655);
    run_access(1'b0, 3'b010, 32'h6, 32'h0, fs, fe, fw, lr, lv, cyc);
    checks++; if (fs !== SPLIT || fe !== !SPLIT || fw !== 1'b0) begin
      errors++; $display("FAIL lw_6_first got s=%b e=%b w=%b want %b %b 0", fs, fe, fw, SPLIT, !SPLIT);
    end
    checks++; if (cyc !== (SPLIT ? 2 : 1) || lv !== SPLIT || lr !== (SPLIT ? 32'h6655_4433 : 32'h0)) begin
      errors++; $display("FAIL lw_6_data got %h v=%b cyc=%0d want %h %b %0d",
                         lr, lv, cyc, SPLIT ? 32'h6655_4433 : 32'h0, SPLIT, SPLIT ? 2 : 1);
    end
    checks++; if (mem_mismatches() != 0) begin
      errors++; $display("FAIL lw_6_mem got %0d changed words want 0", mem_mismatches());
    end

    set_word(WORDS-1, 32'h0);
    set_word(0, 32'hFFFF_FFFF);
    run_access(1'b1, 3'b010, 32'hFFE, 32'hDDCC_BBAA, fs, fe, fw, lr, lv, cyc);
    checks++; if (mem[WORDS-1] !== (SPLIT ? 32'hBBAA_0000 : 32'h0)) begin
      errors++; $display("FAIL sw_wrap_hi got %h want %h", mem[WORDS-1], SPLIT ? 32'hBBAA_0000 : 32'h0);
    end
    checks++; if (mem[0] !== (SPLIT ? 32'hFFFF_DDCC : 32'hFFFF_FFFF)) begin
      errors++; $display("FAIL sw_wrap_lo got %h want %h", mem[0], SPLIT ? 32'hFFFF_DDCC : 32'hFFFF_FFFF);
    end
    checks++; if (fe !== !SPLIT || fw !== SPLIT) begin
      errors++; $display("FAIL sw_wrap_first got e=%b w=%b want %b %b", fe, fw, !SPLIT, SPLIT);
    end
    if (SPLIT) ref_store(32'hFFE, 3'b010, 32'hDDCC_BBAA);
  endtask

`ifdef LSU_MISALIGN_EN
  task automatic test_reset_second();
    logic wr;
    logic [ADDR_W-1:0] wa;
    logic [31:0] wv;
    set_word(8, 32'h0);
    set_word(9, 32'h1234_5678);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h22; wdata = 32'hA1B2_C3D4;
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst2_stall1 got %b want 1", stall); end
    wr = mem_we; wa = mem_addr; wv = mem_wdata;
    @(posedge clk); #1;
    if (wr) mem[wa] = wv;
    @(negedge clk); #2;
    reset = 1'b1; #1;
    checks++; if (stall !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'd8) begin
      errors++; $display("FAIL rst2_idle got s=%b w=%b a=%0d want 0 0 8", stall, mem_we, mem_addr);
    end
    wr = mem_we; wa = mem_addr; wv = mem_wdata;
    @(posedge clk); #1;
    if (wr) mem[wa] = wv;
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    ref_mem[8*4+2] = 8'hD4;
    ref_mem[8*4+3] = 8'hC3;
    checks++; if (mem[8] !== 32'hC3D4_0000) begin errors++; $display("FAIL rst2_first got %h want c3d40000", mem[8]); end
    checks++; if (mem[9] !== 32'h1234_5678) begin errors++; $display("FAIL rst2_second got %h want 12345678", mem[9]); end
  endtask
`endif

  task automatic test_back_to_back();
    logic fs, fe, fw, lv, rej;
    logic [31:0] lr;
    int cyc;
    rej = !SPLIT;
    run_access(1'b1, 3'b010, 32'h11, 32'hCAFE_F00D, fs, fe, fw, lr, lv, cyc);
    if (!rej) ref_store(32'h11, 3'b010, 32'hCAFE_F00D);
    checks++; if (cyc !== (SPLIT ? 2 : 1)) begin errors++; $display("FAIL b2b_sw_cycles got %0d want %0d", cyc, SPLIT ? 2 : 1); end
    run_access(1'b0, 3'b010, 32'h11, 32'h0, fs, fe, fw, lr, lv, cyc);
    checks++; if (lr !== (rej ? 32'h0 : ref_load(32'h11, 3'b010))) begin
      errors++; $display("FAIL b2b_lw got %h want %h", lr, rej ? 32'h0 : ref_load(32'h11, 3'b010));
    end
    run_access(1'b0, 3'b100, 32'h14, 32'h0, fs, fe, fw, lr, lv, cyc);
    checks++; if (lr !== ref_load(32'h14, 3'b100) || lv !== 1'b1 || fs !== 1'b0) begin
      errors++; $display("FAIL b2b_lbu got %h v=%b s=%b want %h 1 0", lr, lv, fs, ref_load(32'h14, 3'b100));
    end
  endtask

  task automatic test_random();
    logic fs, fe, fw, lv, we, misal, rej;
    logic [2:0] f3;
    logic [31:0] a, wd, lr, exp_rd;
    int cyc;
    int unsigned n0, n1;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
        3: f3 = 3'b100; 4: f3 = 3'b101; default: f3 = 3'($urandom_range(6, 7));
      endcase
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a[11:2] = '1;
      wd = $urandom;
      misal = is_misal(a, f3);
      rej = misal && !SPLIT;
      exp_rd = rej ? 32'h0 : ref_load(a, f3);
      run_access(we, f3, a, wd, fs, fe, fw, lr, lv, cyc);
      checks++; if (cyc !== ((misal && SPLIT) ? 2 : 1) || fs !== (misal && SPLIT)) begin
        errors++; $display("FAIL rnd%0d_timing got cyc=%0d s=%b want %0d %b", n, cyc, fs, (misal && SPLIT) ? 2 : 1, misal && SPLIT);
      end
      checks++; if (fe !== rej || fw !== (we && !rej)) begin
        errors++; $display("FAIL rnd%0d_flags got e=%b w=%b want %b %b", n, fe, fw, rej, we && !rej);
      end
      if (!we) begin
        checks++; if (lv !== !rej || lr !== exp_rd) begin
          errors++; $display("FAIL rnd%0d_load a=%h f3=%b got %h v=%b want %h %b", n, a, f3, lr, lv, exp_rd, !rej);
        end
      end else begin
        if (!rej) ref_store(a, f3, wd);
        n0 = a[11:2];
        n1 = (n0 + 1) % WORDS;
        checks++; if (mem[n0] !== ref_word(n0) || mem[n1] !== ref_word(n1)) begin
          errors++; $display("FAIL rnd%0d_store a=%h f3=%b got %h %h want %h %h", n, a, f3, mem[n0], mem[n1], ref_word(n0), ref_word(n1));
        end
      end
    end
    checks++; if (mem_mismatches() != 0) begin
      errors++; $display("FAIL rnd_mem_final got %0d bad words want 0", mem_mismatches());
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0; reset = 1'b1;
    for (int unsigned w = 0; w < WORDS; w++) set_word(w, $urandom);
    test_reset();
    test_directed();
`ifdef LSU_MISALIGN_EN
    test_reset_second();
`endif
    test_back_to_back();
    test_random();
    @(negedge clk); req_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the ALU/register-file datapath and the word-organised data memory. It converts byte addresses into word addresses and turns sub-word stores into full-word read-modify-write. It sign- or zero-extends loaded bytes and halfwords. Misaligned halfword/word accesses are split into two consecutive word accesses, and the core is stalled for one cycle.

## Interface
- ADDR_W, 10: word-address width of data memory (1024 words).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  load or store request present this cycle.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; any other code is treated as W.
- addr  in  32  byte address; bits [31:ADDR_W+2] ignored.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  extended load result.
- rdata_valid  out  1  rdata is final this cycle.
- stall  out  1  hold PC and all request inputs stable next cycle.
- misalign_err  out  1  misaligned access rejected (only without LSU_MISALIGN_EN).
- mem_we  out  1  data-memory write enable.
- mem_addr  out  ADDR_W  word address to data memory.
- mem_wdata  out  32  full word to write.
- mem_load_type  out  3  constant 3'b010; memory is always accessed as full words.
- mem_rdata  in  32  combinational read of word mem_addr.

## Operation
- Byte order is little-endian. Offset off = addr[1:0]; word N = addr[ADDR_W+1:2].
- Access size: B/BU = 1 byte, H/HU = 2 bytes, W = 4 bytes.
- An access is misaligned when off + size > 4. Byte offsets are always aligned; H is misaligned only at off=3; W is misaligned at off≠0.
- Aligned load: mem_addr=N; rdata = selected lanes of mem_rdata, sign-extended (B, H) or zero-extended (BU, HU, W); rdata_valid=1; stall=0.
- Aligned store: mem_addr=N. mem_wdata = mem_rdata with lanes off..off+size-1 replaced by the low bytes of wdata; mem_we=1.
- Misaligned access, FSM IDLE → SECOND → IDLE:
  - IDLE cycle: mem_addr=N, stall=1, rdata_valid=0. Load: bytes off..3 of mem_rdata are captured into lo_reg. Store: lanes off..3 of word N are written (read-modify-write).
  - SECOND cycle: mem_addr = (N+1) mod 2^ADDR_W, stall=0. Load: rdata = {mem_rdata low bytes, lo_reg}, extended; rdata_valid=1. Store: the remaining low lanes of word N+1 are written.
- req_valid=0: mem_we=0, rdata_valid=0, stall=0, and the FSM stays in IDLE. In SECOND, req_valid is guaranteed 1 because the core holds its request.
- mem_we is forced to 0 while reset is high.

## Timing
- Reset values: FSM=IDLE, lo_reg=0, stall=0, misalign_err=0, rdata_valid=0, mem_we=0.
- Aligned accesses have zero-cycle latency; all outputs are combinational from the inputs and mem_rdata.
- Misaligned accesses take 2 cycles and raise exactly one stall cycle. The state register and lo_reg update on the rising clk edge.
- Reset asserted in SECOND returns the FSM to IDLE immediately. For a store, the first-half write is already committed and the second half is lost; this is accepted behaviour.
- Back-to-back requests: a new request is accepted in the cycle after SECOND, with no bubble.

## Configuration
- LSU_MISALIGN_EN defined: misaligned accesses are split as described above.
- LSU_MISALIGN_EN undefined:
  - The FSM and lo_reg are removed.
  - A misaligned request drives misalign_err=1 for that cycle, with mem_we=0, rdata=0, rdata_valid=0 and stall=0.
  - misalign_err is tied to 0 when the macro is defined.

## Test plan
- Word0 = 0x8899AABB. LB addr 0x1 → rdata 0xFFFFFFAA, stall 0. LBU addr 0x2 → 0x00000099. LH addr 0x2 → 0xFFFF8899.
- SB addr 0x3, wdata 0x12345611 → word0 becomes 0x1199AABB. SH addr 0x0, wdata 0xCAFE → word0 becomes 0x1199CAFE.
- Word1 = 0x44332211, word2 = 0x88776655. LW addr 0x6 → stall=1 for one cycle, then rdata 0x66554433 with rdata_valid=1.
- SW addr 0xFFE (N=1023), wdata 0xDDCCBBAA, word1023=0, word0=0xFFFFFFFF → word1023=0xBBAA0000, word0=0xFFFFDDCC (wrap to word 0).
- Reset pulsed during SECOND of a misaligned SW → FSM is IDLE and stall=0 immediately; first-half lanes are written and the second word is unchanged.
- Build without LSU_MISALIGN_EN: LW addr 0x6 → misalign_err=1, mem_we=0, stall=0, memory unchanged.
